// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU types, ALU op codes, forwarding selects and ID/EX stage register layout
// Contents:
//   ALU_* op codes        5-bit ALU operation encodings
//   FWD_* selects         2-bit operand source selects from the forwarding unit
//   idex_reg_t            ID/EX stage register fields
//   IDEX_BUBBLE           all-zero stage register (reset and bubble value)
//   fwd_select()          forwarding decision for one source register

package cpu_pkg;

    localparam logic [4:0] ALU_ADDU  = 5'b00000;
    localparam logic [4:0] ALU_SUBU  = 5'b00001;
    localparam logic [4:0] ALU_AND   = 5'b00010;
    localparam logic [4:0] ALU_OR    = 5'b00011;
    localparam logic [4:0] ALU_XOR   = 5'b00100;
    localparam logic [4:0] ALU_NOR   = 5'b00101;
    localparam logic [4:0] ALU_SLT   = 5'b00110;
    localparam logic [4:0] ALU_SLTU  = 5'b00111;
    localparam logic [4:0] ALU_SLL   = 5'b01000;
    localparam logic [4:0] ALU_SRL   = 5'b01001;
    localparam logic [4:0] ALU_SRA   = 5'b01010;
    localparam logic [4:0] ALU_SLLV  = 5'b01011;
    localparam logic [4:0] ALU_SRLV  = 5'b01100;
    localparam logic [4:0] ALU_SRAV  = 5'b01101;
    localparam logic [4:0] ALU_LUI   = 5'b01110;
    localparam logic [4:0] ALU_ADD   = 5'b01111;
    localparam logic [4:0] ALU_SUB   = 5'b10000;
    localparam logic [4:0] ALU_MULT  = 5'b10001;
    localparam logic [4:0] ALU_MULTU = 5'b10010;
    localparam logic [4:0] ALU_DIV   = 5'b10011;
    localparam logic [4:0] ALU_DIVU  = 5'b10100;
    localparam logic [4:0] ALU_MFHI  = 5'b10101;
    localparam logic [4:0] ALU_MFLO  = 5'b10110;
    localparam logic [4:0] ALU_JR    = 5'b10111;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [31:0] imm;
        logic [4:0]  shamt;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  aluctr;
        logic        alusrc;
        logic        shiftsrc;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic        memtoreg;
    } idex_reg_t;

    // A bubble is an all-zero register: not valid, no writes, addu, rd=$0.
    localparam idex_reg_t IDEX_BUBBLE = '0;

    // EX/MEM is the younger producer, so it wins over MEM/WB; $0 is never forwarded.
    function automatic logic [1:0] fwd_select(
        input logic [4:0] src,
        input logic       exmem_regwrite,
        input logic [4:0] exmem_rd,
        input logic       memwb_regwrite,
        input logic [4:0] memwb_rd
    );
        if (exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == src))
            return FWD_EXMEM;
        else if (memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == src))
            return FWD_MEMWB;
        else
            return FWD_REG;
    endfunction

endpackage

// File: rtl/fwd_unit.sv
// rtl/fwd_unit.sv - combinational RAW forwarding select for the EX-stage rs/rt operands
// Ports:
//   rs, rt                         registered source register numbers in EX
//   exmem_regwrite, exmem_rd       EX/MEM producer tag
//   memwb_regwrite, memwb_rd       MEM/WB producer tag
//   fwd_a, fwd_b                   FWD_* select for rs and rt

module fwd_unit
    import cpu_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic       exmem_regwrite,
    input  logic [4:0] exmem_rd,
    input  logic       memwb_regwrite,
    input  logic [4:0] memwb_rd,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
);

    always_comb begin
        fwd_a = fwd_select(rs, exmem_regwrite, exmem_rd, memwb_regwrite, memwb_rd);
        fwd_b = fwd_select(rt, exmem_regwrite, exmem_rd, memwb_regwrite, memwb_rd);
    end

endmodule

// File: rtl/idex_stage.sv
// rtl/idex_stage.sv - ID/EX pipeline register with forwarding, load-use stall, flush and hold
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   hold, flush                     global freeze; squash of the instruction entering EX
//   id_*                            decoded instruction fields from ID
//   exmem_*, memwb_*                forwarding sources
//   alu_a, alu_b, alu_aluctr        EX-stage ALU operands and op code
//   ex_store_data                   forwarded rt value for stores
//   ex_pc, ex_rd, ex_valid, ex_*    registered instruction fields in EX
//   stall_id                        freeze PC and IF/ID (load-use hazard)

module idex_stage
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        hold,
    input  logic        flush,
    input  logic        id_valid,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_rs_val,
    input  logic [31:0] id_rt_val,
    input  logic [31:0] id_imm,
    input  logic [4:0]  id_shamt,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic [4:0]  id_aluctr,
    input  logic        id_alusrc,
    input  logic        id_shiftsrc,
    input  logic        id_regwrite,
    input  logic        id_memread,
    input  logic        id_memwrite,
    input  logic        id_memtoreg,
    input  logic        exmem_regwrite,
    input  logic [4:0]  exmem_rd,
    input  logic [31:0] exmem_result,
    input  logic        memwb_regwrite,
    input  logic [4:0]  memwb_rd,
    input  logic [31:0] memwb_result,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_aluctr,
    output logic [31:0] ex_store_data,
    output logic [31:0] ex_pc,
    output logic [4:0]  ex_rd,
    output logic        ex_valid,
    output logic        ex_regwrite,
    output logic        ex_memread,
    output logic        ex_memwrite,
    output logic        ex_memtoreg,
    output logic        stall_id
);

    idex_reg_t  ex_r;
    idex_reg_t  id_in;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic [31:0] fwd_rs;
    logic [31:0] fwd_rt;
    logic        src_match;

    always_comb begin
        id_in          = IDEX_BUBBLE;
        id_in.valid    = id_valid;
        id_in.pc       = id_pc;
        id_in.rs_val   = id_rs_val;
        id_in.rt_val   = id_rt_val;
        id_in.imm      = id_imm;
        id_in.shamt    = id_shamt;
        id_in.rs       = id_rs;
        id_in.rt       = id_rt;
        id_in.rd       = id_rd;
        id_in.aluctr   = id_aluctr;
        id_in.alusrc   = id_alusrc;
        id_in.shiftsrc = id_shiftsrc;
        id_in.regwrite = id_regwrite;
        id_in.memread  = id_memread;
        id_in.memwrite = id_memwrite;
        id_in.memtoreg = id_memtoreg;
    end

    // A load in EX cannot forward its data in time for the ID instruction.
    // A flush squashes the ID instruction anyway, so no stall is needed then.
    always_comb begin
        src_match = (id_use_rs && (id_rs == ex_r.rd)) || (id_use_rt && (id_rt == ex_r.rd));
        stall_id  = !flush && ex_r.valid && ex_r.memread && (ex_r.rd != 5'd0)
                    && id_valid && src_match;
    end

    // Hold freezes the register outright, so a stall stays asserted and a
    // flush is lost until the branch logic re-presents it.
    always_ff @(posedge clk) begin
        if (rst)
            ex_r <= IDEX_BUBBLE;
        else if (!hold) begin
            if (flush || stall_id)
                ex_r <= IDEX_BUBBLE;
            else
                ex_r <= id_in;
        end
    end

    fwd_unit u_fwd_unit (
        .rs             (ex_r.rs),
        .rt             (ex_r.rt),
        .exmem_regwrite (exmem_regwrite),
        .exmem_rd       (exmem_rd),
        .memwb_regwrite (memwb_regwrite),
        .memwb_rd       (memwb_rd),
        .fwd_a          (fwd_a),
        .fwd_b          (fwd_b)
    );

    always_comb begin
        case (fwd_a)
            FWD_EXMEM: fwd_rs = exmem_result;
            FWD_MEMWB: fwd_rs = memwb_result;
            default:   fwd_rs = ex_r.rs_val;
        endcase
        case (fwd_b)
            FWD_EXMEM: fwd_rt = exmem_result;
            FWD_MEMWB: fwd_rt = memwb_result;
            default:   fwd_rt = ex_r.rt_val;
        endcase
    end

    assign alu_a         = ex_r.shiftsrc ? {27'b0, ex_r.shamt} : fwd_rs;
    assign alu_b         = ex_r.alusrc ? ex_r.imm : fwd_rt;
    assign alu_aluctr    = ex_r.aluctr;
    assign ex_store_data = fwd_rt;
    assign ex_pc         = ex_r.pc;
    assign ex_rd         = ex_r.rd;
    assign ex_valid      = ex_r.valid;
    assign ex_regwrite   = ex_r.regwrite;
    assign ex_memread    = ex_r.memread;
    assign ex_memwrite   = ex_r.memwrite;
    assign ex_memtoreg   = ex_r.memtoreg;

endmodule

// File: doc/idex_stage.md
# idex_stage

ID/EX pipeline stage that registers decoded instruction fields and produces the ALU operands (`alu_a`, `alu_b`, `alu_aluctr`) consumed directly by the EX-stage ALU. Resolves RAW hazards by forwarding from the EX/MEM and MEM/WB stages. Detects load-use hazards, stalls ID and inserts a bubble. Also handles branch flush and a global pipeline hold.

## Interface
- Parameters: none.
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `hold` in 1: global freeze from the memory side; the stage register keeps its contents.
- `flush` in 1: taken branch or jump; squash the instruction entering EX.
- `id_valid` in 1: ID holds a real instruction.
- `id_pc` in 32: PC of the ID instruction.
- `id_rs_val`, `id_rt_val` in 32 each: register-file read data.
- `id_imm` in 32: immediate, already sign- or zero-extended.
- `id_shamt` in 5: shift amount field.
- `id_rs`, `id_rt`, `id_rd` in 5 each: source register numbers and destination register number.
- `id_use_rs`, `id_use_rt` in 1 each: instruction reads rs / rt.
- `id_aluctr` in 5: ALU operation code.
- `id_alusrc` in 1: B operand is the immediate.
- `id_shiftsrc` in 1: A operand is the shamt field.
- Control flags in 1 each: `id_regwrite`, `id_memread`, `id_memwrite`, `id_memtoreg`.
- `exmem_regwrite` in 1, `exmem_rd` in 5, `exmem_result` in 32: EX/MEM forwarding source.
- `memwb_regwrite` in 1, `memwb_rd` in 5, `memwb_result` in 32: MEM/WB forwarding source.
- `alu_a`, `alu_b` out 32 each: ALU operands.
- `alu_aluctr` out 5: ALU operation code.
- `ex_store_data` out 32: forwarded rt value, for stores.
- `ex_pc` out 32, `ex_rd` out 5, `ex_valid` out 1.
- `ex_regwrite`, `ex_memread`, `ex_memwrite`, `ex_memtoreg` out 1 each.
- `stall_id` out 1: freeze PC and IF/ID.

## Operation
- Stage register fields: valid, pc, rs_val, rt_val, imm, shamt, rs, rt, rd, aluctr, alusrc, shiftsrc, and the four control flags.
- Update priority at each rising edge:
  1. `rst`: every field is 0.
  2. `hold`: register unchanged.
  3. `flush` or `stall_id`: load a bubble.
  4. Otherwise: load the ID inputs.
- Bubble: every field 0. Consequences: `ex_valid`=0, no writes, `alu_aluctr`=5'b00000 (addu), `ex_rd`=0.
- Load-use detection, combinational:
  - `stall_id` = `ex_valid & ex_memread & (ex_rd!=0) & id_valid & ((id_use_rs & id_rs==ex_rd) | (id_use_rt & id_rt==ex_rd))`.
  - `stall_id` is forced to 0 while `flush` is asserted.
- Forwarding, per registered source s (rs, rt), combinational:
  - If `exmem_regwrite & exmem_rd!=0 & exmem_rd==s`: use `exmem_result`.
  - Else if the same test passes on MEM/WB: use `memwb_result`.
  - Else: use the registered read value.
  - Register 0 is never forwarded.
  - EX/MEM has priority when both stages match.
- Operand muxing:
  - `alu_a` = `shiftsrc` ? {27'b0, shamt} : fwd_rs.
  - `alu_b` = `alusrc` ? imm : fwd_rt.
  - `ex_store_data` = fwd_rt, regardless of `alusrc`.
- All remaining `ex_*` outputs are direct register outputs.

## Timing
- Latency: 1 cycle from the ID inputs to the registered `ex_*` fields.
- `alu_a`/`alu_b` settle in the same cycle that the forwarding inputs change; there is no extra latency.
- Reset values: all `ex_*` outputs 0 and `alu_aluctr`=0. With the forwarding inputs at 0, `alu_a`=`alu_b`=0. `stall_id` is 0 one cycle after reset.
- A load-use stall lasts exactly one cycle. The next cycle EX holds a bubble, so `stall_id` drops.
- `hold` with `flush`: hold wins; the flush must be re-presented by the branch logic after the hold.
- `hold` with `stall_id`: the register is held and `stall_id` stays asserted. No bubble is inserted until `hold` drops.
- Reset mid-stall: the next cycle shows a bubble and `stall_id`=0.

## Structure
- Shared package `cpu_pkg`:
  - ALU op constants (`ALU_ADDU`=5'b00000 … `ALU_JR`=5'b10111).
  - Forwarding select encoding: `FWD_REG`=2'b00, `FWD_MEMWB`=2'b01, `FWD_EXMEM`=2'b10.
  - Bubble/reset constant for the stage register.
- One combinational sub-module `fwd_unit`. It takes the registered rs/rt and the EX/MEM and MEM/WB tags, and returns two 2-bit selects. It is instantiated once and reused by the hazard-free path.

## Test plan
- Reset, then `id` add $3=$1+$2 with rs_val=5 and rt_val=7: next cycle `alu_a`=5, `alu_b`=7, `ex_rd`=3, `ex_regwrite`=1.
- Forwarding priority: EX holds rs=4; `exmem_rd`=4 with result 0x11; `memwb_rd`=4 with result 0x22 → `alu_a`=0x11. Drop `exmem_regwrite` → `alu_a`=0x22.
- Register-zero guard: rs=0, `exmem_rd`=0, `exmem_regwrite`=1, result 0xFFFF → `alu_a`=registered rs_val (0).
- Load-use: lw $5 in EX, then add using $5 in ID → `stall_id`=1 for one cycle. Next cycle `ex_valid`=0 and all control flags 0. The following cycle the add appears in EX.
- Flush during a load-use condition → `stall_id`=0, bubble loaded. With `hold`=1 on the same edge → register unchanged.
- Shift and immediate selection:
  - `shiftsrc`=1, shamt=8 → `alu_a`=8.
  - `alusrc`=1, imm=0xFFFFFFFC → `alu_b`=0xFFFFFFFC, while `ex_store_data` still equals the forwarded rt.
